// File: rtl/switch_cmd_pkg.sv
// switch_cmd_pkg: opcodes, command word fields and sequencer states for the MT8816 feeder
package switch_cmd_pkg;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_CONNECT = 4'b0010;
  localparam int CMD_RST_BIT = 15;
  localparam int CMD_DATA_BIT = 11;
  localparam int CMD_AY_MSB = 9;
  localparam int CMD_AY_LSB = 7;
  localparam int CMD_SW_BIT = 4;
  localparam int CMD_AX_MSB = 3;
  localparam int CMD_AX_LSB = 0;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;
  function automatic logic [3:0] cmd_op(input logic [15:0] w);
    return w[CMD_RST_BIT] ? OP_RESET : OP_CONNECT;
  endfunction
  function automatic logic [15:0] cmd_data(input logic [15:0] w);
    return {1'b0, w[CMD_RST_BIT-1:0]};
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH x 16 synchronous FIFO with registered full/empty/level
module cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     rd_en,
  output logic [15:0]              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LV = DEPTH[AW:0];
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_level, w_next;
  logic r_full, r_empty, w_wr, w_rd;
  assign w_rd = rd_en && !r_empty;
  // a pop frees a slot in the same cycle, so a write at full is still taken
  assign w_wr = wr_en && (!r_full || w_rd);
  assign w_next = r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
  assign rd_data = r_mem[r_rp];
  assign full = r_full;
  assign empty = r_empty;
  assign level = r_level;
  assign drop = wr_en && !w_wr;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= wr_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_level <= w_next;
      r_full <= w_next == FULL_LV;
      r_empty <= w_next == '0;
    end
  end
endmodule

// File: rtl/switch_command_sequencer.sv
// switch_command_sequencer: buffers switch commands and drains them into the MT8816
// interface one at a time over the cs/op/data/rdy handshake, with per-command timeout.
module switch_command_sequencer
  import switch_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 64,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [15:0]            wr_data,
  input  logic                   go,
  input  logic                   abort,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   wr_drop,
  output logic                   sw_cs,
  output logic [3:0]             sw_op,
  output logic [15:0]            sw_data,
  input  logic                   sw_rdy
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam state_t S_RST = INIT_CLEAR ? S_INIT : S_IDLE;
  state_t r_state;
  logic [7:0] r_cnt;
  logic [15:0] w_head, r_data;
  logic [3:0] r_op;
  logic r_cs, r_busy, r_done, r_terr, r_drop, r_init, r_abort;
  logic w_pop, w_drop, w_abort, w_finish;
  assign w_pop = r_state == S_ISSUE;
  assign w_abort = r_abort || abort;
  assign w_finish = sw_rdy ? (r_init || empty || w_abort) : (r_cnt == TO_LAST);
  assign sw_cs = r_cs;
  assign sw_op = r_op;
  assign sw_data = r_data;
  assign busy = r_busy;
  assign done = r_done;
  assign timeout_err = r_terr;
  assign wr_drop = r_drop;
  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(w_pop),
    .rd_data(w_head), .full(full), .empty(empty), .level(level), .drop(w_drop)
  );
  // the cs pulse becomes visible in the cycle after ISSUE/INIT, i.e. while in GAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
      r_cnt <= '0;
      r_cs <= 1'b0;
      r_op <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_terr <= 1'b0;
      r_drop <= 1'b0;
      r_init <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_cs <= 1'b0;
      r_done <= 1'b0;
      if (w_drop) r_drop <= 1'b1;
      if (abort && r_state != S_IDLE) r_abort <= 1'b1;
      case (r_state)
        S_INIT: begin
          r_cs <= 1'b1;
          r_op <= OP_RESET;
          r_data <= '0;
          r_init <= 1'b1;
          r_busy <= 1'b1;
          r_state <= S_GAP;
        end
        S_IDLE: begin
          r_done <= go && empty;
          if (go && !empty) begin
            r_terr <= 1'b0;
            r_busy <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cs <= 1'b1;
          r_op <= cmd_op(w_head);
          r_data <= cmd_data(w_head);
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_op <= '0;
          r_cnt <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (!sw_rdy && r_cnt == TO_LAST) r_terr <= 1'b1;
          if (w_finish) begin
            r_done <= !r_init;
            r_init <= 1'b0;
            r_abort <= 1'b0;
            r_busy <= 1'b0;
            r_state <= S_IDLE;
          end else if (sw_rdy) r_state <= S_ISSUE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_command_sequencer.sv
// tb_switch_command_sequencer: directed checks of init clear, drain, timeout, overflow, abort and reset
module tb_switch_command_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, go = 1'b0, abort = 1'b0, hold = 1'b0;
  logic [15:0] wr_data = '0;
  logic full, empty, busy, done, timeout_err, wr_drop, sw_cs, sw_rdy;
  logic [4:0] level;
  logic [3:0] sw_op;
  logic [15:0] sw_data;
  int n_cmp = 0, n_err = 0, cyc = 0, rdy_cnt = 0, n_done = 0, done_cyc = 0, hits;
  logic [3:0] cs_op[$];
  logic [15:0] cs_data[$];
  logic cs_rdy[$];
  int cs_cyc[$];

  switch_command_sequencer #(.DEPTH(16), .TIMEOUT(64), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .go(go), .abort(abort),
    .full(full), .empty(empty), .level(level), .busy(busy), .done(done),
    .timeout_err(timeout_err), .wr_drop(wr_drop), .sw_cs(sw_cs), .sw_op(sw_op),
    .sw_data(sw_data), .sw_rdy(sw_rdy)
  );

  always #5 clk = ~clk;

  // switch interface model: rdy drops after each cs and returns 8 cycles later
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rdy_cnt = 0;
      sw_rdy = 1'b1;
    end else begin
      if (sw_cs) begin
        cs_op.push_back(sw_op);
        cs_data.push_back(sw_data);
        cs_rdy.push_back(sw_rdy);
        cs_cyc.push_back(cyc);
        rdy_cnt = 8;
        sw_rdy = 1'b0;
      end else if (rdy_cnt > 1) rdy_cnt--;
      else begin
        rdy_cnt = 0;
        sw_rdy = 1'b1;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (hold) sw_rdy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic clear_mon();
    cs_op.delete();
    cs_data.delete();
    cs_rdy.delete();
    cs_cyc.delete();
    n_done = 0;
  endtask

  task automatic wait_idle(input string tag, input int max_c);
    for (int i = 0; i < max_c; i++) begin
      if (!busy) break;
      tick();
    end
    chk(tag, busy, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_drop"}, wr_drop, 0);
    chk({tag, "_cs"}, sw_cs, 0);
    chk({tag, "_op"}, sw_op, 0);
    chk({tag, "_data"}, sw_data, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk_reset("rst0");
    clear_mon();
    rst = 1'b0;
    tick();
    chk("init_busy", busy, 1);
    wait_idle("init_idle", 40);
    tick();
    chk("init_ncs", cs_op.size(), 1);
    if (cs_op.size() == 1) begin
      chk("init_op", cs_op[0], 4'b0001);
      chk("init_data", cs_data[0], 16'h0000);
    end
    chk("init_ndone", n_done, 0);

    clear_mon();
    push(16'h0885);
    push(16'h0013);
    chk("two_level", level, 2);
    pulse_go();
    chk("two_busy", busy, 1);
    wait_idle("two_idle", 60);
    chk("two_done_hi", done, 1);
    tick();
    chk("two_done_lo", done, 0);
    chk("two_ndone", n_done, 1);
    chk("two_ncs", cs_op.size(), 2);
    if (cs_op.size() == 2) begin
      chk("two_op0", cs_op[0], 4'b0010);
      chk("two_data0", cs_data[0], 16'h0885);
      chk("two_op1", cs_op[1], 4'b0010);
      chk("two_data1", cs_data[1], 16'h0013);
      chk("two_rdy1", cs_rdy[1], 1);
      chk("two_spacing", cs_cyc[1] - cs_cyc[0], 10);
    end
    chk("two_empty", empty, 1);

    clear_mon();
    push(16'h8000);
    pulse_go();
    wait_idle("rstcmd_idle", 40);
    tick();
    chk("rstcmd_ncs", cs_op.size(), 1);
    if (cs_op.size() == 1) begin
      chk("rstcmd_op", cs_op[0], 4'b0001);
      chk("rstcmd_data", cs_data[0], 16'h0000);
    end

    clear_mon();
    hold = 1'b1;
    push(16'h0021);
    push(16'h0022);
    push(16'h0023);
    pulse_go();
    wait_idle("to_idle", 120);
    chk("to_terr", timeout_err, 1);
    chk("to_done", done, 1);
    chk("to_level", level, 2);
    tick();
    chk("to_ndone", n_done, 1);
    chk("to_ncs", cs_op.size(), 1);
    if (cs_op.size() == 1) chk("to_latency", done_cyc - cs_cyc[0], 65);
    hold = 1'b0;
    tick();
    clear_mon();
    pulse_go();
    chk("to_terr_clr", timeout_err, 0);
    wait_idle("to_rest_idle", 60);
    chk("to_rest_level", level, 0);
    tick();
    chk("to_rest_ncs", cs_op.size(), 2);
    if (cs_op.size() == 2) chk("to_rest_data1", cs_data[1], 16'h0023);

    clear_mon();
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_drop", wr_drop, 0);
    pulse_go();
    push(16'h0AAA);
    chk("wp_level", level, 16);
    chk("wp_full", full, 1);
    chk("wp_drop", wr_drop, 0);
    push(16'h0DDD);
    chk("ovf_drop", wr_drop, 1);
    chk("ovf_level", level, 16);
    wait_idle("ovf_idle", 400);
    tick();
    chk("ovf_ncs", cs_op.size(), 17);
    hits = 0;
    foreach (cs_data[i]) if (cs_data[i] == 16'h0DDD) hits++;
    chk("ovf_dropped_never_issued", hits, 0);
    if (cs_op.size() == 17) begin
      chk("ovf_first", cs_data[0], 16'h0100);
      chk("ovf_last", cs_data[16], 16'h0AAA);
    end
    chk("ovf_ndone", n_done, 1);

    clear_mon();
    for (int i = 0; i < 4; i++) push(16'h0011 + 16'(i));
    pulse_go();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle("ab_idle", 40);
    chk("ab_done", done, 1);
    chk("ab_level", level, 3);
    tick();
    chk("ab_ncs", cs_op.size(), 1);
    if (cs_op.size() == 1) chk("ab_data", cs_data[0], 16'h0011);

    pulse_go();
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset("mid");
    tick();
    clear_mon();
    rst = 1'b0;
    tick();
    chk("reinit_busy", busy, 1);
    wait_idle("reinit_idle", 40);
    tick();
    chk("reinit_ncs", cs_op.size(), 1);
    if (cs_op.size() == 1) begin
      chk("reinit_op", cs_op[0], 4'b0001);
      chk("reinit_data", cs_data[0], 16'h0000);
    end
    chk("reinit_ndone", n_done, 0);
    chk("reinit_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/switch_command_sequencer.md
Name: switch_command_sequencer

Overview:
- Upstream feeder for the MT8816 crosspoint switch interface.
- Buffers host-written 16-bit switch command words in a small FIFO.
- On `go`, drains the FIFO into the switch interface one command at a time, using its cs/op/data_in/rdy handshake.
- Gives the host batch programming of a connection map, with a per-command timeout.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥2).
- TIMEOUT, 64, max cycles to wait for sw_rdy per command (≤255).
- INIT_CLEAR, 1, if 1 a matrix-reset command is issued automatically after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  16  command word: [15]=matrix-reset flag, [11]=DATA, [9:7]=AY, [4]=switch select, [3:0]=logical X.
- go  in  1  start drain (1-cycle pulse).
- abort  in  1  stop after current command.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  drain or init in progress.
- done  out  1  1-cycle pulse at end of drain.
- timeout_err  out  1  sticky; set on timeout.
- wr_drop  out  1  sticky; set on write while full.
- sw_cs  out  1  to switch interface cs.
- sw_op  out  4  to switch interface op.
- sw_data  out  16  to switch interface data_in.
- sw_rdy  in  1  from switch interface rdy.

Behaviour:
- Async reset values:
  - All outputs 0 except empty=1.
  - FIFO pointers 0; state S_INIT if INIT_CLEAR=1, else S_IDLE.
- All outputs are registered.
- Op encoding:
  - OP_CONNECT=4'b0010, used when word[15]=0.
  - OP_RESET=4'b0001, used when word[15]=1.
  - sw_data=word with bit15 forced 0.
- FIFO:
  - Write accepted when wr_en && !full.
  - Write while full is dropped and sets wr_drop.
  - A pop and a write in the same cycle are both honoured; level is unchanged.
- S_INIT: drive sw_cs=1, sw_op=OP_RESET, sw_data=0 for 1 cycle, then go to S_GAP with the "init" tag set. busy=1.
- S_IDLE:
  - sw_cs=0, busy=0.
  - go with empty=0: clear timeout_err, go to S_ISSUE.
  - go with empty=1: done pulse next cycle, stay in S_IDLE.
- S_ISSUE (1 cycle): sw_cs=1, sw_op/sw_data from FIFO head; pop head; go to S_GAP.
- S_GAP (1 cycle): sw_cs=0, sw_op=0; lets the switch interface clear rdy; reset wait counter; go to S_WAIT.
- S_WAIT: counter increments each cycle.
  - sw_rdy=1 observed: if !empty && !abort_pending go to S_ISSUE; else go to S_IDLE with done=1 for one cycle.
  - Counter reaches TIMEOUT before sw_rdy: set timeout_err, go to S_IDLE with done=1. Remaining FIFO entries are retained.
- After init, S_WAIT returns to S_IDLE without a done pulse.
- abort:
  - Latched as abort_pending while busy; cleared on entry to S_IDLE.
  - Never truncates an in-flight sw_cs pulse.
- Writes during a drain are appended and drained in the same run.
- go while busy is ignored.
- Min spacing between sw_cs pulses is 3 cycles (ISSUE, GAP, WAIT≥1); real spacing is set by sw_rdy.
- Reset mid-drain: everything returns to reset values immediately, FIFO contents are discarded, and the init clear is reissued if INIT_CLEAR=1.

Decomposition:
- Package switch_cmd_pkg:
  - OP_RESET, OP_CONNECT.
  - Command bit positions (CMD_RST_BIT=15, CMD_SW_BIT=4, CMD_AY_MSB/LSB=9/7, CMD_DATA_BIT=11, CMD_AX_MSB/LSB=3/0).
  - State localparams S_INIT, S_IDLE, S_ISSUE, S_GAP, S_WAIT.
- Sub-module cmd_fifo (parameterised DEPTH×16 synchronous FIFO, registered full/empty/level, async reset).

Test Plan:
- Reset with INIT_CLEAR=1, sw_rdy model drops 1 cycle after cs and rises 8 cycles later -> one sw_cs pulse with sw_op=4'b0001, sw_data=16'h0000; busy falls; no done pulse.
- Write 16'h0885, 16'h0013, pulse go -> two sw_cs pulses, sw_op=4'b0010, sw_data=16'h0885 then 16'h0013, each issued only after sw_rdy=1; done=1 for exactly 1 cycle; empty=1.
- Write 16'h8000, go -> sw_op=4'b0001, sw_data=16'h0000.
- Hold sw_rdy=0 with TIMEOUT=64 and 3 entries -> timeout_err=1 at 64 cycles after GAP; done pulse; level=2.
- Write DEPTH+1 words -> full=1, level=16, wr_drop=1, 17th word never issued; simultaneous write+pop at full keeps level=16 with no drop.
- Assert abort during the first of 4 commands -> only 1 sw_cs pulse, done pulse, level=3; then assert rst mid-drain -> level=0, all outputs reset, init clear reissued.
